// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, widths and the issuer FSM state type.
package alu_pkg;

  localparam int OPW  = 3;
  localparam int RESW = 6;

  localparam logic [OPW-1:0] OP_NOP  = 3'b000;
  localparam logic [OPW-1:0] OP_ADD  = 3'b001;
  localparam logic [OPW-1:0] OP_SUB  = 3'b010;
  localparam logic [OPW-1:0] OP_MUL  = 3'b011;
  localparam logic [OPW-1:0] OP_SHR  = 3'b100;
  localparam logic [OPW-1:0] OP_SHL  = 3'b101;
  localparam logic [OPW-1:0] OP_XNOR = 3'b110;
  localparam logic [OPW-1:0] OP_SGT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } issuer_state_e;

  function automatic logic is_nop(input logic [OPW-1:0] op);
    return op == OP_NOP;
  endfunction

endpackage

// File: rtl/alu_issuer.sv
// Sequences one command at a time onto the ALU and returns its result.
// Optional accumulator feedback into operand a: define ALU_ISSUER_ACC_EN.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
`ifdef ALU_ISSUER_ACC_EN
  input  logic            cmd_use_acc,
`endif
  output logic [OPW-1:0]  alu_opcode,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic            alu_execute,
  input  logic [RESW-1:0] alu_f,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RESW-1:0] rsp_f,
  output logic [OPW-1:0]  rsp_op,
  output logic            busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  issuer_state_e  state;
  logic [3:0]     wait_cnt;
  logic [OPW-1:0] next_a;

`ifdef ALU_ISSUER_ACC_EN
  logic [RESW-1:0] acc;
  assign next_a = cmd_use_acc ? acc[OPW-1:0] : cmd_a;
`else
  assign next_a = cmd_a;
`endif

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_execute <= 1'b0;
      rsp_f       <= '0;
      rsp_op      <= '0;
`ifdef ALU_ISSUER_ACC_EN
      acc         <= '0;
`endif
    end else begin
      alu_execute <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_opcode <= cmd_op;
            alu_a      <= next_a;
            alu_b      <= cmd_b;
            // A NOP never touches the ALU; its response is ready immediately.
            if (is_nop(cmd_op)) begin
              rsp_f  <= '0;
              rsp_op <= OP_NOP;
              state  <= S_DONE;
            end else begin
              state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          alu_execute <= 1'b1;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Capture on the last wait cycle; a count of 0 is treated like 1.
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= '0;
            rsp_f    <= alu_f;
            rsp_op   <= alu_opcode;
`ifdef ALU_ISSUER_ACC_EN
            acc      <= alu_f;
`endif
            state    <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issuer.md
# alu_issuer

Sequencing front-end that drives the 3-bit ALU's `opcodein`/`a`/`b`/`execute` inputs and collects its 6-bit `f` result. It accepts one command at a time over a valid/ready handshake. It applies the operands with setup and hold margin around a one-cycle `execute` pulse, captures the result, and returns it over a second valid/ready handshake. It sits between the user/command logic and the ALU, and is the only block that drives the ALU.

## Interface
- `WAIT_CYCLES`, 1: cycles `execute` stays low, with operands held, before `alu_f` is sampled; legal range 1..15.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 3: opcode (see package).
- `cmd_a` in 3: operand a.
- `cmd_b` in 3: operand b.
- `alu_opcode` out 3: to ALU `opcodein`.
- `alu_a` out 3: to ALU `a`.
- `alu_b` out 3: to ALU `b`.
- `alu_execute` out 1: to ALU `execute`; registered; one-cycle pulse.
- `alu_f` in 6: from ALU `f`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_f` out 6: captured result.
- `rsp_op` out 3: opcode that produced `rsp_f`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → SETUP on `cmd_valid && cmd_ready`.
  - SETUP → EXEC.
  - EXEC → WAIT.
  - WAIT → DONE after `WAIT_CYCLES` cycles, via a 4-bit down-counter.
  - DONE → IDLE on `rsp_valid && rsp_ready`.
- Handshake signals:
  - `cmd_ready` = 1 only in IDLE and not in reset.
  - `rsp_valid` = 1 only in DONE.
- Accept: `cmd_op`/`cmd_a`/`cmd_b` are registered into `alu_opcode`/`alu_a`/`alu_b`. These outputs hold unchanged until the next accept.
- EXEC: `alu_execute` = 1 for exactly that cycle. It is 0 in every other state.
- Capture: on the last WAIT cycle, `alu_f` is registered into `rsp_f`, and `alu_opcode` into `rsp_op`.
- NOP (`cmd_op` = 0): IDLE → DONE directly. No `execute` pulse, `rsp_f` = 0, ALU operand outputs still update.
- `rsp_f`/`rsp_op` hold stable while `rsp_valid` = 1 and `rsp_ready` = 0. There is no timeout.
- `cmd_valid` while busy is ignored. The upstream holds the command until `cmd_ready`.
- No width conversion: `rsp_f` is `alu_f` bit-for-bit. Wrap and truncation are the ALU's arithmetic, not this block's.

## Timing
- Reset values: state IDLE and all outputs 0 (`cmd_ready` 0 during `rst`, 1 the first cycle after). The WAIT counter resets to 0.
- Latency for accept at edge T:
  - Operands are valid from T+1.
  - `alu_execute` is high during cycle T+2, so operands have one full cycle of setup before its rise.
  - Operands and `execute` = 0 are held during WAIT.
  - `rsp_valid` rises at cycle T+3+`WAIT_CYCLES` (T+4 by default).
- NOP latency: `rsp_valid` at T+1.
- Back-to-back: a response handshake at edge R gives `cmd_ready` = 1 in cycle R+1. Minimum period is 4+`WAIT_CYCLES` cycles.
- Reset mid-operation: the next edge forces IDLE and `alu_execute` = 0. Any partially executed command is dropped with no response.

## Configuration
- `ALU_ISSUER_ACC_EN` defined:
  - Adds input `cmd_use_acc` (1 bit) and a 6-bit accumulator register, reset to 0.
  - The accumulator loads `alu_f` on every non-NOP capture.
  - When `cmd_use_acc` = 1 at accept, `alu_a` is taken from `acc[2:0]` instead of `cmd_a`.
- Undefined: no port and no register; `alu_a` always comes from `cmd_a`.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants as 3-bit binary: NOP 3'b000, ADD 3'b001, SUB 3'b010, MUL 3'b011, SHR 3'b100, SHL 3'b101, XNOR 3'b110, SGT 3'b111.
  - State enum for IDLE/SETUP/EXEC/WAIT/DONE.
  - Result width 6 and operand width 3.
- No sub-modules; one FSM plus datapath registers.

## Test plan
- Bench drives an ALU behavioural model sampling on `posedge alu_execute`.
- ADD a=3, b=4 → exactly one `execute` pulse at T+2, `rsp_f` = 7, `rsp_op` = 1, `rsp_valid` at T+4.
- SUB a=2, b=5 → `rsp_f` = 6'd61. MUL 7×7 → 49. SHL 5, 2 → 20. SGT 5, 3 → 1.
- NOP → no `execute` edge, `rsp_f` = 0, `rsp_valid` at T+1.
- `rsp_ready` held 0 for 10 cycles:
  - `rsp_f` stable throughout and `cmd_ready` = 0.
  - A new `cmd_valid` is ignored until the response handshake completes.
- `rst` asserted in cycle T+2 (EXEC) → `alu_execute` = 0 next cycle, no `rsp_valid`, and `cmd_ready` = 1 the cycle after `rst` falls.
- With `ALU_ISSUER_ACC_EN` defined:
  - ADD 3+4 → acc = 7.
  - Then ADD with `cmd_use_acc`=1, b=1 → `alu_a` = 7, `rsp_f` = 8.
